// File: rtl/vec_pkg.sv
// Shared vector definitions used by the reduction unit, the vALU and the decoder.
// Holds the default register width, the legal element widths, the reduction
// opcode encodings and the reduction FSM state type.
package vec_pkg;

  localparam int unsigned VLEN = 128;

  localparam logic [7:0] SEW_E8   = 8'd8;
  localparam logic [7:0] SEW_E16  = 8'd16;
  localparam logic [7:0] SEW_E32  = 8'd32;
  localparam logic [7:0] SEW_E64  = 8'd64;
  localparam logic [7:0] SEW_E128 = 8'd128;

  typedef enum logic [1:0] {
    RED_SUM  = 2'b00,
    RED_SMIN = 2'b01,
    RED_SMAX = 2'b10,
    RED_UMAX = 2'b11
  } red_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } vred_state_e;

  function automatic logic sew_is_legal(input logic [7:0] s);
    return (s == SEW_E8) || (s == SEW_E16) || (s == SEW_E32) ||
           (s == SEW_E64) || (s == SEW_E128);
  endfunction

endpackage

// File: rtl/vred_elem_op.sv
// Per-element reduction combine (purely combinational).
// Ports:
//   a_i    : current accumulator
//   b_i    : element, already aligned to bit 0
//   mask_i : ones in bits [SEW-1:0]
//   sbit_i : single one at bit SEW-1 (element sign bit)
//   op_i   : reduction opcode (sum / signed min / signed max / unsigned max)
//   y_o    : new accumulator, masked to SEW bits
module vred_elem_op #(
  parameter int unsigned VLEN = vec_pkg::VLEN
) (
  input  logic [VLEN-1:0] a_i,
  input  logic [VLEN-1:0] b_i,
  input  logic [VLEN-1:0] mask_i,
  input  logic [VLEN-1:0] sbit_i,
  input  logic [1:0]      op_i,
  output logic [VLEN-1:0] y_o
);
  import vec_pkg::*;

  logic [VLEN-1:0] a;
  logic [VLEN-1:0] b;
  logic [VLEN-1:0] sum;
  logic [VLEN-1:0] sa;
  logic [VLEN-1:0] sb;

  always_comb begin
    a   = a_i & mask_i;
    b   = b_i & mask_i;
    sum = (a + b) & mask_i;
    // Flipping the SEW sign bit turns a two's complement compare into an
    // unsigned one, so one comparator width serves every SEW.
    sa  = a ^ sbit_i;
    sb  = b ^ sbit_i;
    y_o = a;
    // Strict compares: on a tie the accumulator keeps its value.
    case (red_op_e'(op_i))
      RED_SUM:  y_o = sum;
      RED_SMIN: if (sb < sa) y_o = b;
      RED_SMAX: if (sb > sa) y_o = b;
      RED_UMAX: if (b > a)   y_o = b;
      default:  y_o = a;
    endcase
  end

endmodule

// File: rtl/vred_unit.sv
// Sequential vector reduction unit: folds one SEW-bit element per cycle into a
// single accumulator, starting from scalar_in[SEW-1:0].
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   in_valid / in_ready     : request handshake (vec_in, scalar_in, red_op, SEW)
//   out_valid / out_ready   : result handshake (res, sew_err)
//   busy                    : high whenever the FSM is not idle
module vred_unit #(
  parameter int unsigned VLEN = vec_pkg::VLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [VLEN-1:0] vec_in,
  input  logic [VLEN-1:0] scalar_in,
  input  logic [1:0]      red_op,
  input  logic [7:0]      SEW,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [VLEN-1:0] res,
  output logic            sew_err,
  output logic            busy
);
  import vec_pkg::*;

  vred_state_e     state_q, state_d;
  logic [VLEN-1:0] vec_q,   vec_d;
  logic [VLEN-1:0] acc_q,   acc_d;
  logic [4:0]      idx_q,   idx_d;
  logic [1:0]      op_q,    op_d;
  logic [7:0]      sew_q,   sew_d;
  logic            err_q,   err_d;
  logic            ovld_q,  ovld_d;

  logic [VLEN-1:0] mask_in;
  logic [VLEN-1:0] mask_run;
  logic [VLEN-1:0] sbit_run;
  logic [12:0]     shamt;
  logic [VLEN-1:0] elem;
  logic [VLEN-1:0] comb_y;
  logic            legal_in;

  function automatic logic [4:0] last_idx(input logic [7:0] s);
    case (s)
      SEW_E8:  return 5'(VLEN / 8 - 1);
      SEW_E16: return 5'(VLEN / 16 - 1);
      SEW_E32: return 5'(VLEN / 32 - 1);
      SEW_E64: return 5'(VLEN / 64 - 1);
      default: return 5'd0;
    endcase
  endfunction

  always_comb begin
    legal_in = sew_is_legal(SEW) && (32'(SEW) <= VLEN);
    // Shifting by a full VLEN yields zero, so SEW=VLEN gives an all-ones mask.
    mask_in  = ~({VLEN{1'b1}} << SEW);
    mask_run = ~({VLEN{1'b1}} << sew_q);
    sbit_run = mask_run ^ (mask_run >> 1);
    shamt    = 13'(idx_q) * 13'(sew_q);
    elem     = vec_q >> shamt;
  end

  vred_elem_op #(.VLEN(VLEN)) u_elem_op (
    .a_i    (acc_q),
    .b_i    (elem),
    .mask_i (mask_run),
    .sbit_i (sbit_run),
    .op_i   (op_q),
    .y_o    (comb_y)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    op_d    = op_q;
    sew_d   = sew_q;
    err_d   = err_q;
    ovld_d  = ovld_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          vec_d = vec_in;
          op_d  = red_op;
          sew_d = SEW;
          idx_d = '0;
          if (legal_in) begin
            acc_d   = scalar_in & mask_in;
            err_d   = 1'b0;
            state_d = ST_RUN;
          end else begin
            acc_d   = '0;
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        acc_d = comb_y;
        idx_d = idx_q + 5'd1;
        if (idx_q == last_idx(sew_q)) state_d = ST_DONE;
      end
      ST_DONE: begin
        // out_valid is registered one cycle after entering DONE, giving the
        // N+1 cycle accept-to-result latency (1 cycle for an illegal SEW).
        if (!ovld_q) begin
          ovld_d = 1'b1;
        end else if (out_ready) begin
          ovld_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      op_q    <= '0;
      sew_q   <= '0;
      err_q   <= 1'b0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      sew_q   <= sew_d;
      err_q   <= err_d;
      ovld_q  <= ovld_d;
    end
  end

  // acc is always held masked to SEW, so it doubles as the zero-extended result.
  assign res       = acc_q;
  assign sew_err   = err_q;
  assign out_valid = ovld_q;
  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vred_unit.sv
module tb_vred_unit;

  localparam int unsigned VLEN = 128;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [VLEN-1:0] vec_in;
  logic [VLEN-1:0] scalar_in;
  logic [1:0]      red_op;
  logic [7:0]      SEW;
  logic            out_valid;
  logic            out_ready;
  logic [VLEN-1:0] res;
  logic            sew_err;
  logic            busy;

  int total;
  int bad;

  vred_unit #(.VLEN(VLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .vec_in    (vec_in),
    .scalar_in (scalar_in),
    .red_op    (red_op),
    .SEW       (SEW),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .sew_err   (sew_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Issue one request, scramble inputs and keep in_valid high while busy,
  // measure latency, hold the result for 'hold' cycles, then hand it off.
  task automatic run_req(input string tag, input logic [7:0] sew, input logic [1:0] op,
                         input logic [VLEN-1:0] vec, input logic [VLEN-1:0] sc,
                         input logic [VLEN-1:0] exp_res, input logic exp_err,
                         input int exp_lat, input int hold);
    int cyc;
    @(negedge clk);
    SEW = sew; red_op = op; vec_in = vec; scalar_in = sc;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    check({tag, "_busy"}, VLEN'(busy), VLEN'(1));
    check({tag, "_inrdy_busy"}, VLEN'(in_ready), VLEN'(0));
    vec_in = ~vec; scalar_in = ~sc; red_op = op + 2'd1; SEW = 8'd24;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, "_lat"}, VLEN'(cyc), VLEN'(exp_lat));
    check({tag, "_res"}, res, exp_res);
    check({tag, "_err"}, VLEN'(sew_err), VLEN'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_res"}, res, exp_res);
      check({tag, "_hold_inrdy"}, VLEN'(in_ready), VLEN'(0));
      check({tag, "_hold_ov"}, VLEN'(out_valid), VLEN'(1));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, VLEN'(out_valid), VLEN'(0));
    check({tag, "_inrdy_back"}, VLEN'(in_ready), VLEN'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VLEN-1:0] v;
    logic [VLEN-1:0] s;
    logic            seen;
    total = 0; bad = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    vec_in = '0; scalar_in = '0; red_op = 2'b00; SEW = 8'd8;
    #12;
    check("rst_inrdy", VLEN'(in_ready), VLEN'(1));
    check("rst_ov", VLEN'(out_valid), VLEN'(0));
    check("rst_busy", VLEN'(busy), VLEN'(0));
    check("rst_res", res, '0);
    check("rst_err", VLEN'(sew_err), VLEN'(0));
    @(negedge clk); rst_n = 1'b1;

    // SEW=8 sum: 16 x 1 + 5 = 0x15
    v = {16{8'h01}};
    run_req("s8sum", 8'd8, 2'b00, v, {{120{1'b1}}, 8'h05}, VLEN'(8'h15), 1'b0, 17, 0);

    // SEW=16 signed min / unsigned max on the same lanes
    v = {16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF};
    run_req("s16smin", 8'd16, 2'b01, v, '0, VLEN'(16'h8000), 1'b0, 9, 0);
    run_req("s16umax", 8'd16, 2'b11, v, '0, VLEN'(16'hFFFF), 1'b0, 9, 0);

    // SEW=32 sum wraps: 4 + 4*(-1) = 0
    run_req("s32wrap", 8'd32, 2'b00, '1, VLEN'(32'h4), '0, 1'b0, 5, 0);

    // SEW=128 signed max, positive element beats 0; hold result 5 cycles
    v = 128'h00112233445566778899AABBCCDDEEFF;
    run_req("s128smax", 8'd128, 2'b10, v, '0, v, 1'b0, 2, 5);

    // SEW=128 signed max, negative element loses to scalar 0
    run_req("s128neg", 8'd128, 2'b10, {1'b1, 127'h5}, '0, '0, 1'b0, 2, 0);

    // Illegal SEW
    run_req("sew24", 8'd24, 2'b00, '1, '1, '0, 1'b1, 1, 0);

    // SEW=64 signed max, upper scalar bits must be ignored
    v = {64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000};
    s = {64'hDEADBEEFDEADBEEF, 64'hFFFFFFFFFFFFFFFE};
    run_req("s64smax", 8'd64, 2'b10, v, s, VLEN'(64'hFFFFFFFFFFFFFFFF), 1'b0, 3, 0);

    // SEW=8 bytes i*0x11
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'(i * 17);
    run_req("s8smax", 8'd8, 2'b10, v, VLEN'(8'h80), VLEN'(8'h77), 1'b0, 17, 0);
    run_req("s8umax", 8'd8, 2'b11, v, '0, VLEN'(8'hFF), 1'b0, 17, 0);
    run_req("s8smin", 8'd8, 2'b01, v, '0, VLEN'(8'h88), 1'b0, 17, 0);

    // Reset mid-RUN
    @(negedge clk);
    SEW = 8'd8; red_op = 2'b00; vec_in = {16{8'h01}}; scalar_in = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_inrdy", VLEN'(in_ready), VLEN'(1));
    check("mrst_ov", VLEN'(out_valid), VLEN'(0));
    check("mrst_busy", VLEN'(busy), VLEN'(0));
    check("mrst_res", res, '0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("mrst_no_ov", VLEN'(seen), VLEN'(0));
    check("mrst_inrdy2", VLEN'(in_ready), VLEN'(1));

    // Sum of 0..15 = 120 plus 0x10 = 0x88
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'(i);
    run_req("post_rst", 8'd8, 2'b00, v, VLEN'(8'h10), VLEN'(8'h88), 1'b0, 17, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
